// File: rtl/datacache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// memory stage and a data memory with a combinational block-read port.
module datacache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3,
    parameter int SETS          = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ADDRESS_WIDTH-1:0]              cpu_address,
    input  logic                                  cpu_read,
    input  logic                                  cpu_write,
    input  logic [DATA_WIDTH-1:0]                 cpu_write_data,
    output logic [DATA_WIDTH-1:0]                 cpu_read_data,
    output logic                                  stall,
    output logic [ADDRESS_WIDTH-1:0]              mem_address,
    output logic [DATA_WIDTH-1:0]                 mem_write_data,
    output logic                                  mem_write_enable,
    input  logic [(2**BLOCK_SIZE)*DATA_WIDTH-1:0] mem_read_data,
    output logic [31:0]                           hit_count,
    output logic [31:0]                           miss_count
);
    localparam int S     = 2**BLOCK_SIZE;
    localparam int LINES = 2**SETS;
    localparam int TAG_W = ADDRESS_WIDTH - BLOCK_SIZE - SETS;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                   r_state;
    logic [LINES-1:0]         r_valid;
    logic [TAG_W-1:0]         r_tag  [LINES];
    logic [DATA_WIDTH-1:0]    r_data [LINES][S];
    logic                     r_refilled;
    logic [ADDRESS_WIDTH-1:0] r_miss_addr;
    logic [31:0]              r_hit_count;
    logic [31:0]              r_miss_count;

    logic [BLOCK_SIZE-1:0]    w_off;
    logic [SETS-1:0]          w_idx;
    logic [TAG_W-1:0]         w_tag;
    logic [SETS-1:0]          w_midx;
    logic [TAG_W-1:0]         w_mtag;
    logic                     w_hit;
    logic                     w_load;

    assign w_off  = cpu_address[BLOCK_SIZE-1:0];
    assign w_idx  = cpu_address[BLOCK_SIZE+SETS-1:BLOCK_SIZE];
    assign w_tag  = cpu_address[ADDRESS_WIDTH-1:BLOCK_SIZE+SETS];
    assign w_midx = r_miss_addr[BLOCK_SIZE+SETS-1:BLOCK_SIZE];
    assign w_mtag = r_miss_addr[ADDRESS_WIDTH-1:BLOCK_SIZE+SETS];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // a store wins over a simultaneous load
    assign w_load = cpu_read && !cpu_write;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    always_comb begin
        cpu_read_data    = '0;
        stall            = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        if (!rst) begin
            if (r_state == IDLE) begin
                mem_address      = cpu_address;
                mem_write_data   = cpu_write_data;
                mem_write_enable = cpu_write;
                stall            = w_load && !w_hit;
                if (w_load && w_hit)
                    cpu_read_data = r_data[w_idx][w_off];
            end else begin
                stall       = 1'b1;
                mem_address = {r_miss_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_refilled   <= 1'b0;
            r_miss_addr  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == IDLE) begin
            r_refilled <= 1'b0;
            if (w_load && w_hit) begin
                // the retry right after a refill is not a genuine hit
                if (!r_refilled)
                    r_hit_count <= r_hit_count + 32'd1;
            end else if (w_load) begin
                r_miss_addr  <= cpu_address;
                r_miss_count <= r_miss_count + 32'd1;
                r_state      <= REFILL;
            end
        end else begin
            r_valid[w_midx] <= 1'b1;
            r_refilled      <= 1'b1;
            r_state         <= IDLE;
        end
    end

    // line payload carries no reset; valid bits alone qualify it
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == REFILL) begin
                r_tag[w_midx] <= w_mtag;
                for (int w = 0; w < S; w++)
                    r_data[w_midx][w] <= mem_read_data[w*DATA_WIDTH +: DATA_WIDTH];
            end else if (cpu_write && w_hit) begin
                r_data[w_idx][w_off] <= cpu_write_data;
            end
        end
    end
endmodule

// File: tb/tb_datacache.sv
// Directed bench for datacache with a behavioural word memory that commits
// writes on the falling edge and serves whole blocks combinationally.
module tb_datacache;
    logic         clk = 1'b0;
    logic         rst;
    logic [29:0]  cpu_address;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_write_data;
    logic [31:0]  cpu_read_data;
    logic         stall;
    logic [29:0]  mem_address;
    logic [31:0]  mem_write_data;
    logic         mem_write_enable;
    logic [255:0] mem_read_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [1024];
    bit          mem_ready = 1'b0;

    datacache dut (
        .clk(clk), .rst(rst),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
        .stall(stall), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[16'h10] <= 32'hDEADBEEF;
            mem_ready   <= 1'b1;
        end else if (mem_write_enable) begin
            mem[mem_address[9:0]] <= mem_write_data;
        end
    end

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            mem_read_data[i*32 +: 32] = mem[{mem_address[9:3], 3'(i)}];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one quiet cycle; leaves time at posedge+3 for checks
    task automatic idle();
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
    endtask

    task automatic do_load(input logic [29:0] a, input logic [31:0] exp, input int exp_st,
                           input string tag);
        int st = 0;
        @(posedge clk); #1;
        cpu_address = a; cpu_read = 1'b1; cpu_write = 1'b0;
        #2;
        while (stall && st < 8) begin
            st++;
            @(posedge clk); #3;
        end
        chk({tag, "_stalls"}, 32'(st), 32'(exp_st));
        chk({tag, "_data"}, cpu_read_data, exp);
    endtask

    task automatic do_store(input logic [29:0] a, input logic [31:0] d, input logic rd,
                            input string tag);
        @(posedge clk); #1;
        cpu_address = a; cpu_write_data = d; cpu_write = 1'b1; cpu_read = rd;
        #2;
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_write_enable}, 32'd1);
        chk({tag, "_addr"}, {2'b0, mem_address}, {2'b0, a});
        chk({tag, "_wdata"}, mem_write_data, d);
        chk({tag, "_rdata"}, cpu_read_data, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cpu_address = 30'h10; cpu_read = 1'b1; cpu_write = 1'b1;
        cpu_write_data = 32'hAAAA_AAAA;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_rdata", cpu_read_data, 32'd0);
        chk("rst_maddr", {2'b0, mem_address}, 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
        #2;
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_miss", miss_count, 32'd0);

        do_load(30'h10, 32'hDEADBEEF, 2, "first");
        idle();
        chk("first_miss", miss_count, 32'd1);
        chk("first_hits", hit_count, 32'd0);

        do_load(30'h13, 32'h1000_0013, 0, "spatial");
        idle();
        chk("spatial_hits", hit_count, 32'd1);

        do_store(30'h11, 32'h12345678, 1'b0, "sthit");
        idle();
        chk("sthit_we_off", {31'd0, mem_write_enable}, 32'd0);
        chk("sthit_mem", mem[16'h11], 32'h12345678);
        do_load(30'h11, 32'h12345678, 0, "sthit_ld");
        idle();
        chk("sthit_hits", hit_count, 32'd2);

        do_store(30'h12, 32'h55AA_55AA, 1'b1, "rwprio");
        idle();
        chk("rwprio_hits", hit_count, 32'd2);
        chk("rwprio_miss", miss_count, 32'd1);
        do_load(30'h12, 32'h55AA_55AA, 0, "rwprio_ld");

        do_reset();
        do_store(30'h40, 32'hCAFEF00D, 1'b0, "stmiss");
        idle();
        chk("stmiss_miss0", miss_count, 32'd0);
        do_load(30'h40, 32'hCAFEF00D, 2, "stmiss_ld");
        idle();
        chk("stmiss_miss", miss_count, 32'd1);

        do_reset();
        do_load(30'h000, 32'h1000_0000, 2, "conf0");
        do_load(30'h100, 32'h1000_0100, 2, "conf1");
        do_load(30'h000, 32'h1000_0000, 2, "conf2");
        idle();
        chk("conf_miss", miss_count, 32'd3);
        chk("conf_hits", hit_count, 32'd0);

        do_reset();
        @(posedge clk); #1;
        cpu_address = 30'h23; cpu_read = 1'b1;
        #2;
        chk("mid_c0_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #3;
        chk("mid_refill_addr", {2'b0, mem_address}, 32'h20);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        cpu_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("mid_hits", hit_count, 32'd0);
        chk("mid_miss0", miss_count, 32'd0);
        do_load(30'h20, 32'h1000_0020, 2, "mid_ld");
        idle();
        chk("mid_miss", miss_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
